// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, ROM access and 2-entry IF/ID buffer
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        rom_ce_q, rom_ce_d;
    logic [31:0] buf_pc_q   [2];
    logic [31:0] buf_pc_d   [2];
    logic [31:0] buf_inst_q [2];
    logic [31:0] buf_inst_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        pop;
    logic        push;
    logic        head_valid;

    assign head_valid = (count_q != 2'd0);
    assign pop        = head_valid & id_ready;
    // A full buffer still accepts a word when decode drains the head this cycle.
    assign push       = rom_ce_q & ~branch_flag_i & ((count_q < 2'd2) | pop);

    assign rom_ce   = rom_ce_q;
    assign rom_addr = fetch_pc_q;
    assign id_valid = head_valid;
    assign id_pc    = head_valid ? buf_pc_q[rd_ptr_q]   : 32'h0000_0000;
    assign id_inst  = head_valid ? buf_inst_q[rd_ptr_q] : 32'h0000_0000;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rom_ce_d   = 1'b1;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (branch_flag_i) begin
            // Redirect flushes everything; a same-cycle pop needs no extra work.
            fetch_pc_d = {branch_target_i[31:2], 2'b00};
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (push) begin
                buf_pc_d[wr_ptr_q]   = fetch_pc_q;
                buf_inst_d[wr_ptr_q] = rom_inst;
                wr_ptr_d             = ~wr_ptr_q;
                fetch_pc_d           = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rom_ce_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]   <= 32'h0000_0000;
                buf_inst_q[i] <= 32'h0000_0000;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rom_ce_q   <= rom_ce_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]   <= buf_pc_d[i];
                buf_inst_q[i] <= buf_inst_d[i];
            end
        end
    end

endmodule
